// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory / program loader slice.
// Holds the loader state encoding, the memory geometry constants and the
// instruction field offsets used by the control unit decoder.
package cpu_pkg;

  localparam int unsigned IW    = 9;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  // Instruction layout: {opcode[2:0], ra1[1:0], ra2[1:0], wa[1:0]}
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned RA1_LSB = 4;
  localparam int unsigned RA2_LSB = 2;
  localparam int unsigned WA_LSB  = 0;
  localparam int unsigned REG_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x IW instruction storage.
// Ports:
//   clk   - write clock
//   we    - write enable (commits on rising edge)
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - asynchronous read data
// Contents are never cleared; the loader masks unwritten words.
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a streaming program loader.
// A host streams IW-bit words over ld_valid/ld_ready; the control unit
// fetches combinationally via pc. Words at or past prog_len read as 0
// with instr_valid low.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start_load          - begin a new load (from idle/ready)
//   ld_valid/ld_data/ld_last, ld_ready - load stream handshake
//   run_req, cpu_done, run - execution control
//   pc, instr, instr_valid - fetch port
//   prog_len            - loaded word count (0..DEPTH)
//   overflow            - sticky: memory filled before ld_last
//   csum                - XOR of loaded words
// Build option: define IMEM_CHECKSUM_EN to build the checksum register;
// otherwise csum is tied to 0.
module imem_loader #(
  parameter int unsigned DEPTH = cpu_pkg::DEPTH,
  parameter int unsigned AW    = cpu_pkg::AW,
  parameter int unsigned IW    = cpu_pkg::IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run_req,
  input  logic          cpu_done,
  output logic          run,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW:0]   prog_len,
  output logic          overflow,
  output logic [IW-1:0] csum
);

  import cpu_pkg::*;

  localparam int unsigned LW = AW + 1;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          accept;
  logic [IW-1:0] rd_word;

  // ld_ready is a pure state decode, so accept has no path back to ld_ready.
  assign ld_ready = (state == S_LOAD);
  assign run      = (state == S_RUN);
  assign accept   = ld_ready && ld_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      prog_len <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (start_load) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            prog_len <= '0;
            overflow <= 1'b0;
          end else if (state == S_READY && run_req && prog_len != '0) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (accept) begin
            // At the last slot prog_len naturally rolls to DEPTH and wr_ptr wraps.
            wr_ptr   <= wr_ptr + AW'(1);
            prog_len <= prog_len + LW'(1);
            if (ld_last) begin
              state <= S_READY;
            end else if (wr_ptr == AW'(DEPTH - 1)) begin
              state    <= S_READY;
              overflow <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cpu_done) state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if ((state == S_IDLE || state == S_READY) && start_load) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum ^ ld_data;
    end
  end
`else
  assign csum = '0;
`endif

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (ld_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  assign instr_valid = ({1'b0, pc} < prog_len);
  assign instr       = instr_valid ? rd_word : '0;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_load;
  logic       ld_valid;
  logic [8:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       run_req;
  logic       cpu_done;
  logic       run;
  logic [7:0] pc;
  logic [8:0] instr;
  logic       instr_valid;
  logic [8:0] prog_len;
  logic       overflow;
  logic [8:0] csum;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [8:0] exp_mem [256];
  logic [8:0] exp_csum;

  typedef struct {
    logic [7:0] pc;
    logic [8:0] instr;
    logic       valid;
  } rd_vec_t;

  rd_vec_t tbl [7];

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH (256),
    .AW    (8),
    .IW    (9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_load  (start_load),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .run_req     (run_req),
    .cpu_done    (cpu_done),
    .run         (run),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .overflow    (overflow),
    .csum        (csum)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] csum_exp();
`ifdef IMEM_CHECKSUM_EN
    return exp_csum;
`else
    return 9'h000;
`endif
  endfunction

  task automatic do_start();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    exp_csum   = '0;
  endtask

  task automatic beat(input logic [8:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
  endtask

  initial begin
    logic [8:0] d;
    int unsigned nacc;

    tbl[0] = '{8'd0,   9'h0A5, 1'b1};
    tbl[1] = '{8'd1,   9'h1C6, 1'b1};
    tbl[2] = '{8'd2,   9'h0FF, 1'b1};
    tbl[3] = '{8'd3,   9'h000, 1'b0};
    tbl[4] = '{8'd4,   9'h000, 1'b0};
    tbl[5] = '{8'd128, 9'h000, 1'b0};
    tbl[6] = '{8'd255, 9'h000, 1'b0};

    reset = 1'b1; start_load = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    run_req = 0; cpu_done = 0; pc = 8'd0; exp_csum = '0;
    #3;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_run", run, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_csum", csum, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    #9 reset = 1'b0;
    tick();

    // run_req with nothing loaded
    pulse_run();
    chk("run_empty", run, 0);
    tick();
    chk("run_empty2", run, 0);

    // Load with ld_valid toggling; idle cycles carry junk and ld_last
    do_start();
    chk("ld_ready_start", ld_ready, 1);
    nacc = 0;
    for (int unsigned c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin
        d = tbl[nacc].instr;
        exp_mem[nacc] = d;
        exp_csum ^= d;
        beat(d, nacc == 2);
        pc = nacc[7:0];
        #1;
        chk("wr_readback", instr, d);
        nacc++;
      end else begin
        ld_data = 9'h1FF; ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        chk("ld_ready_steady", ld_ready, 1);
        chk("len_gap", prog_len, nacc);
      end
      if (nacc == 3) break;
    end
    chk("len3", prog_len, 3);
    chk("ready_after_last", ld_ready, 0);
    chk("ovf3", overflow, 0);
    chk("csum3", csum, csum_exp());
    for (int unsigned i = 0; i < 7; i++) begin
      pc = tbl[i].pc;
      #1;
      chk("tbl_instr", instr, tbl[i].instr);
      chk("tbl_valid", instr_valid, tbl[i].valid);
    end

    // run / done / rerun
    pulse_run();
    chk("run_on", run, 1);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    chk("start_in_run_ignored", ld_ready, 0);
    pulse_done();
    chk("run_off", run, 0);
    chk("len_kept", prog_len, 3);
    pulse_run();
    chk("rerun_on", run, 1);
    pulse_done();
    chk("rerun_off", run, 0);

    // 256 beats, no ld_last -> overflow
    do_start();
    chk("ovf_cleared", overflow, 0);
    chk("len_cleared", prog_len, 0);
    for (int unsigned i = 0; i < 256; i++) begin
      d = 9'((i * 37 + 5) % 512);
      exp_mem[i] = d;
      exp_csum ^= d;
      beat(d, 1'b0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_len", prog_len, 256);
    chk("ovf_ld_ready", ld_ready, 0);
    chk("ovf_csum", csum, csum_exp());
    pc = 8'd128; #1;
    chk("ovf_instr128", instr, exp_mem[128]);
    pc = 8'd255; #1;
    chk("ovf_instr255", instr, exp_mem[255]);
    chk("ovf_valid255", instr_valid, 1);

    // 256 beats with ld_last on the final one -> no overflow
    do_start();
    for (int unsigned i = 0; i < 256; i++) begin
      d = 9'((i * 11 + 2) % 512);
      exp_mem[i] = d;
      beat(d, i == 255);
    end
    chk("full_last_ovf", overflow, 0);
    chk("full_last_len", prog_len, 256);
    pc = 8'd255; #1;
    chk("full_last_instr", instr, exp_mem[255]);

    // reset mid-load after 2 of 5 beats
    do_start();
    beat(9'h011, 1'b0);
    beat(9'h022, 1'b0);
    chk("pre_rst_len", prog_len, 2);
    #1 reset = 1'b1;
    #1;
    chk("midrst_len", prog_len, 0);
    chk("midrst_ready", ld_ready, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_csum", csum, 0);
    #2 reset = 1'b0;
    tick();
    do_start();
    exp_csum = 9'h133;
    beat(9'h133, 1'b1);
    chk("fresh_len", prog_len, 1);
    chk("fresh_csum", csum, csum_exp());
    pc = 8'd0; #1;
    chk("fresh_instr", instr, 9'h133);
    pc = 8'd1; #1;
    chk("fresh_mask", instr_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
